// File: rtl/serial_add_pkg.sv
// Shared types for the bit-serial adder sequencer.
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } sadd_state_t;

  localparam int SADD_MAX_WIDTH = 64;

endpackage

// File: rtl/sadd_shift_reg.sv
// Right-shifting register with parallel load; serial data enters at the MSB
// and leaves at the LSB. Serves both as operand PISO and as sum SIPO.
module sadd_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             areset_i,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             shift,
  input  logic             ser_in,
  output logic             ser_out,
  output logic [WIDTH-1:0] q
);

  // Reset wins over load, load wins over shift.
  always_ff @(posedge clk_i) begin
    if (areset_i) begin
      q <= '0;
    end else if (load) begin
      q <= load_val;
    end else if (shift) begin
      q <= {ser_in, q[WIDTH-1:1]};
    end
  end

  assign ser_out = q[0];

endmodule

// File: rtl/serial_add_seq.sv
// Bit-serial adder sequencer around an external registered full-adder stage.
// Operands go out LSB-first, the stage's carry-out is looped back as the next
// carry-in, and its sum bits are shifted into a result register.
// Optional build macro SERIAL_ADD_OVF_EN adds a signed-overflow output ovf_o.
//
// Handshakes: an input transfer happens on a rising edge where valid_i and
// ready_o are both high; a result transfer happens on a rising edge where
// valid_o and ready_i are both high. valid_o and its data never change while
// waiting for ready_i, and valid_i is ignored whenever ready_o is low.
module serial_add_seq
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             areset_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             fa_a_o,
  output logic             fa_b_o,
  output logic             fa_cin_o,
  input  logic             fa_s_i,
  input  logic             fa_cout_i,
`ifdef SERIAL_ADD_OVF_EN
  output logic             ovf_o,
`endif
  output logic [1:0]       state_o
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  sadd_state_t       state_q, state_d;
  logic [CW-1:0]     cnt_q;
  logic              cin_q;
  logic              cout_q;
  logic              accept;
  logic              a_ser, b_ser;
  logic              sum_shift;
  logic [WIDTH-1:0]  a_unused, b_unused;
  logic              sum_ser_unused;

  assign accept  = valid_i && (state_q == IDLE);
  assign state_o = state_q;

  // Next state and all combinational outputs.
  always_comb begin
    state_d  = state_q;
    ready_o  = 1'b0;
    valid_o  = 1'b0;
    fa_a_o   = 1'b0;
    fa_b_o   = 1'b0;
    fa_cin_o = 1'b0;
    case (state_q)
      IDLE: begin
        ready_o = 1'b1;
        if (valid_i) state_d = RUN;
      end
      RUN: begin
        fa_a_o   = a_ser;
        fa_b_o   = b_ser;
        // First bit uses the accepted carry-in, later bits the looped carry.
        fa_cin_o = (cnt_q == '0) ? cin_q : fa_cout_i;
        if (cnt_q == LAST_BIT) state_d = DRAIN;
      end
      DRAIN: state_d = DONE;
      DONE: begin
        valid_o = 1'b1;
        if (ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (areset_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Bit counter: advances in RUN, holds at the last bit, clears elsewhere.
  always_ff @(posedge clk_i) begin
    if (areset_i) begin
      cnt_q <= '0;
    end else if (state_q == RUN) begin
      if (cnt_q != LAST_BIT) cnt_q <= cnt_q + 1'b1;
    end else begin
      cnt_q <= '0;
    end
  end

  // Carry-in latch on accept; final carry-out captured in DRAIN.
  always_ff @(posedge clk_i) begin
    if (areset_i) begin
      cin_q  <= 1'b0;
      cout_q <= 1'b0;
    end else begin
      if (accept)           cin_q  <= cin_i;
      if (state_q == DRAIN) cout_q <= fa_cout_i;
    end
  end

  sadd_shift_reg #(.WIDTH(WIDTH)) u_a_piso (
    .clk_i   (clk_i),
    .areset_i(areset_i),
    .load    (accept),
    .load_val(a_i),
    .shift   (state_q == RUN),
    .ser_in  (1'b0),
    .ser_out (a_ser),
    .q       (a_unused)
  );

  sadd_shift_reg #(.WIDTH(WIDTH)) u_b_piso (
    .clk_i   (clk_i),
    .areset_i(areset_i),
    .load    (accept),
    .load_val(b_i),
    .shift   (state_q == RUN),
    .ser_in  (1'b0),
    .ser_out (b_ser),
    .q       (b_unused)
  );

  // The stage's sum arrives one cycle late: bit k-1 during RUN bit k, last bit in DRAIN.
  assign sum_shift = ((state_q == RUN) && (cnt_q != '0)) || (state_q == DRAIN);

  sadd_shift_reg #(.WIDTH(WIDTH)) u_sum_sipo (
    .clk_i   (clk_i),
    .areset_i(areset_i),
    .load    (1'b0),
    .load_val('0),
    .shift   (sum_shift),
    .ser_in  (fa_s_i),
    .ser_out (sum_ser_unused),
    .q       (sum_o)
  );

  assign cout_o = cout_q;

`ifdef SERIAL_ADD_OVF_EN
  logic cmsb_q;
  logic ovf_q;

  // Carry into the MSB is latched at the last RUN bit; overflow formed in DRAIN.
  always_ff @(posedge clk_i) begin
    if (areset_i) begin
      cmsb_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      if ((state_q == RUN) && (cnt_q == LAST_BIT)) cmsb_q <= fa_cin_o;
      if (state_q == DRAIN)                         ovf_q  <= cmsb_q ^ fa_cout_i;
    end
  end

  assign ovf_o = ovf_q;
`endif

endmodule

// File: tb/tb_serial_add_seq.sv
// Self-checking bench for serial_add_seq with a registered full-adder model.
module tb_serial_add_seq;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         areset;
  logic [W-1:0] a, b;
  logic         cin, valid_in, ready_out;
  logic [W-1:0] sum;
  logic         cout, valid_out, ready_in;
  logic         fa_a, fa_b, fa_cin, fa_s, fa_cout;
  logic [1:0]   dbg_state;
  logic         ovf;

  int checks = 0;
  int errors = 0;
  logic [W:0] exp_q[$];

  serial_add_seq #(.WIDTH(W)) dut (
    .clk_i    (clk),
    .areset_i (areset),
    .a_i      (a),
    .b_i      (b),
    .cin_i    (cin),
    .valid_i  (valid_in),
    .ready_o  (ready_out),
    .sum_o    (sum),
    .cout_o   (cout),
    .valid_o  (valid_out),
    .ready_i  (ready_in),
    .fa_a_o   (fa_a),
    .fa_b_o   (fa_b),
    .fa_cin_o (fa_cin),
    .fa_s_i   (fa_s),
    .fa_cout_i(fa_cout),
`ifdef SERIAL_ADD_OVF_EN
    .ovf_o    (ovf),
`endif
    .state_o  (dbg_state)
  );

`ifndef SERIAL_ADD_OVF_EN
  assign ovf = 1'b0;
`endif

  // Clock.
  always #5 clk = ~clk;

  // Registered full-adder stage model sharing the sequencer's reset.
  always_ff @(posedge clk) begin
    if (areset) begin
      fa_s    <= 1'b0;
      fa_cout <= 1'b0;
    end else begin
      fa_s    <= fa_a ^ fa_b ^ fa_cin;
      fa_cout <= (fa_a & fa_b) | (fa_a & fa_cin) | (fa_b & fa_cin);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for valid_o, recording fa_cin_o per RUN bit; returns edges waited.
  task automatic wait_result(input string tag, output int lat, output logic [W-1:0] cvec);
    lat  = 0;
    cvec = '0;
    while (!valid_out && lat < 40) begin
      if (lat < W) cvec[lat] = fa_cin;
      tick();
      lat++;
    end
    if (!valid_out) check({tag, "_timeout"}, 64'(valid_out), 64'd1);
  endtask

  task automatic check_result(input string tag, input logic [W-1:0] es, input logic ec,
                              input logic eo);
    check({tag, "_sum"}, 64'(sum), 64'(es));
    check({tag, "_cout"}, 64'(cout), 64'(ec));
`ifdef SERIAL_ADD_OVF_EN
    check({tag, "_ovf"}, 64'(ovf), 64'(eo));
`else
    if (eo === 1'bx) check({tag, "_ovf"}, 64'(ovf), 64'd0);
`endif
  endtask

  // One complete operation with ready_i high; all expectations hand-computed.
  task automatic do_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic cv, input logic [W-1:0] es, input logic ec, input logic eo,
                       input logic [W-1:0] ecvec);
    int         lat;
    logic [W-1:0] cvec;
    check({tag, "_ready"}, 64'(ready_out), 64'd1);
    a = av; b = bv; cin = cv; valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
    wait_result(tag, lat, cvec);
    check({tag, "_latency"}, 64'(lat), 64'(W + 1));
    check({tag, "_cinseq"}, 64'(cvec), 64'(ecvec));
    check_result(tag, es, ec, eo);
    tick();
    check({tag, "_post_valid"}, 64'(valid_out), 64'd0);
    check({tag, "_post_ready"}, 64'(ready_out), 64'd1);
    check({tag, "_post_facin"}, 64'(fa_cin), 64'd0);
  endtask

  initial begin
    int           lat, done_cnt, last_h, cyc;
    logic [W-1:0] cvec;
    logic         acc, hand;

    areset = 1'b1; a = '0; b = '0; cin = 1'b0; valid_in = 1'b0; ready_in = 1'b1;
    tick();
    tick();
    // Reset state.
    check("rst_ready", 64'(ready_out), 64'd1);
    check("rst_valid", 64'(valid_out), 64'd0);
    check("rst_sum", 64'(sum), 64'd0);
    check("rst_cout", 64'(cout), 64'd0);
    check("rst_fa", 64'({fa_a, fa_b, fa_cin}), 64'd0);
    check("rst_ovf", 64'(ovf), 64'd0);
    areset = 1'b0;
    tick();

    // Directed operations.
    do_op("t1", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1, 8'hF0);
    do_op("t2", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 8'hFE);
    do_op("t3", 8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1, 8'hFF);

    // Backpressure in DONE with a second request pending.
    ready_in = 1'b0;
    a = 8'h80; b = 8'h80; cin = 1'b0; valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
    wait_result("t4a", lat, cvec);
    a = 8'h12; b = 8'h34; cin = 1'b1; valid_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("t4_hold_valid", 64'(valid_out), 64'd1);
      check("t4_hold_ready", 64'(ready_out), 64'd0);
      check_result("t4_hold", 8'h00, 1'b1, 1'b1);
      tick();
    end
    ready_in = 1'b1;
    tick();
    check("t4_idle_ready", 64'(ready_out), 64'd1);
    check("t4_idle_valid", 64'(valid_out), 64'd0);
    tick();
    valid_in = 1'b0;
    wait_result("t4b", lat, cvec);
    check("t4b_latency", 64'(lat), 64'(W + 1));
    check_result("t4b", 8'h47, 1'b0, 1'b0);
    tick();

    // Reset in the middle of RUN at bit 3.
    a = 8'hFF; b = 8'hFF; cin = 1'b1; valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
    tick(); tick(); tick();
    check("t5_in_run_fa_a", 64'(fa_a), 64'd1);
    areset = 1'b1;
    tick();
    check("t5_ready", 64'(ready_out), 64'd1);
    check("t5_valid", 64'(valid_out), 64'd0);
    check("t5_sum", 64'(sum), 64'd0);
    check("t5_fa", 64'({fa_a, fa_b, fa_cin}), 64'd0);
    areset = 1'b0;
    tick();
    do_op("t5op", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, 8'h02);

    // Random back-to-back operations with valid_i held high.
    done_cnt = 0; last_h = -1; cyc = 0;
    a = W'($urandom_range(0, 255)); b = W'($urandom_range(0, 255));
    cin = 1'($urandom_range(0, 1)); valid_in = 1'b1;
    while (done_cnt < 200 && cyc < 3000) begin
      acc  = valid_in && ready_out;
      hand = valid_out && ready_in;
      if (acc) exp_q.push_back({1'b0, a} + {1'b0, b} + (W + 1)'(cin));
      if (hand) begin
        if (exp_q.size() == 0) begin
          check("rnd_unexpected", 64'({cout, sum}), 64'h1FF_FFFF);
        end else begin
          check("rnd_result", 64'({cout, sum}), 64'(exp_q.pop_front()));
        end
        if (last_h >= 0) check("rnd_interval", 64'(cyc - last_h), 64'(W + 3));
        last_h = cyc;
        done_cnt++;
      end
      tick();
      cyc++;
      if (acc) begin
        a = W'($urandom_range(0, 255)); b = W'($urandom_range(0, 255));
        cin = 1'($urandom_range(0, 1));
      end
    end
    valid_in = 1'b0;
    check("rnd_count", 64'(done_cnt), 64'd200);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
